// File: rtl/booth_radix4_seq_mul.sv
// booth_radix4_seq_mul
//   Sequential radix-4 Booth multiplier. One Booth digit (two multiplier
//   bits) is retired per clock into a 2*(WIDTH+2)-bit accumulator.
//
//   Optional build macro: BOOTH_EARLY_TERM_EN
//     defined   : stop RUN as soon as all remaining Booth digits are zero
//     undefined : fixed N = (WIDTH+2)/2 RUN cycles
//
//   Ports
//     Clk     in   rising-edge clock
//     Reset   in   asynchronous, active-high reset
//     Start   in   request, sampled only in IDLE
//     Sign    in   1 = signed operands, 0 = unsigned (sampled with Start)
//     A       in   WIDTH multiplicand (sampled with Start)
//     B       in   WIDTH multiplier (sampled with Start)
//     Busy    out  high while in RUN
//     Done    out  one-cycle pulse, Product valid in that cycle
//     Product out  2*WIDTH result, held until the next completed operation
module booth_radix4_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Sign,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int unsigned E  = WIDTH + 2;
    localparam int unsigned N  = E / 2;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [2*E-1:0]       r_m;
    logic [2*E-1:0]       r_p;
    logic [E-1:0]         r_q;
    logic                 r_qm1;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [E-1:0]         w_a_ext;
    logic [E-1:0]         w_b_ext;
    logic [2*E-1:0]       w_m_shift;
    logic [2*E-1:0]       w_addend;
    logic [2*E-1:0]       w_p_next;
    logic [E-1:0]         w_q_next;
    logic                 w_last;

    // Two extra bits keep unsigned operands positive in Booth form.
    assign w_a_ext = {{2{Sign & A[WIDTH-1]}}, A};
    assign w_b_ext = {{2{Sign & B[WIDTH-1]}}, B};

    always_comb begin
        w_m_shift = r_m << {r_cnt, 1'b0};
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_m_shift;
            3'b011:         w_addend = w_m_shift << 1;
            3'b100:         w_addend = -(w_m_shift << 1);
            3'b101, 3'b110: w_addend = -w_m_shift;
            default:        w_addend = '0;
        endcase
        w_p_next = r_p + w_addend;
        w_q_next = {{2{r_q[E-1]}}, r_q[E-1:2]};
        w_last   = (r_cnt == CW'(N - 1));
`ifdef BOOTH_EARLY_TERM_EN
        // Remaining multiplier bits all equal the new Qm1: every later
        // digit is 000 or 111, so P is already final.
        if (w_q_next == {E{r_q[1]}}) begin
            w_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_m     <= {{E{w_a_ext[E-1]}}, w_a_ext};
                        r_q     <= w_b_ext;
                        r_qm1   <= 1'b0;
                        r_p     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_qm1 <= r_q[1];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Product is loaded on the same edge that raises
                        // Done so both are valid in the DONE cycle.
                        r_product <= w_p_next[2*WIDTH-1:0];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Product = r_product;

endmodule
